crt_recombine: RTL and testbench

//  Final RSA-CRT decryption stage (Garner recombination). Consumes half-size results
//  mp = c^dp mod p and mq = c^dq mod q, plus qinv = q^-1 mod p from the n0prime/qinv stage.

---
 rtl/crt_pkg.sv | 17 +
 rtl/modmul_serial.sv | 60 ++++++
 rtl/crt_recombine.sv | 137 +++++++++++++
 tb/tb_crt_recombine.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/crt_pkg.sv
// Shared definitions for the CRT recombination datapath.
// Holds default widths and the controller state encoding.
package crt_pkg;

  localparam int W_DEF     = 512;
  localparam int CNT_W_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_DIFF,
    S_MUL_MOD,
    S_MUL_Q,
    S_FINISH
  } state_t;

endpackage

// File: rtl/modmul_serial.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n, MSB-first over b.
// Ports: clk, rst_n, start (load/clear), a, b, n (W), r (W), done (last-iteration strobe).
module modmul_serial
  import crt_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] r,
  output logic         done
);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_b;

  // W+2 bits hold 2*acc + a without overflow
  logic [W+1:0] w_n;
  logic [W+1:0] w_a2;
  logic [W+1:0] w_a2r;
  logic [W+1:0] w_a3;
  logic [W+1:0] w_a3r;

  assign w_n   = {2'b00, n};
  assign w_a2  = {1'b0, r_acc, 1'b0};
  assign w_a2r = (w_a2 >= w_n) ? w_a2 - w_n : w_a2;
  assign w_a3  = w_a2r + (r_b[W-1] ? {2'b00, a} : '0);
  assign w_a3r = (w_a3 >= w_n) ? w_a3 - w_n : w_a3;

  // a is sampled from the cycle after start, so it may load with start
  assign done = r_run && (r_cnt == CNT_W'(W-1));
  assign r    = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_b   <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_acc <= '0;
      r_b   <= b;
    end else if (r_run) begin
      r_acc <= w_a3r[W-1:0];
      r_b   <= r_b << 1;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/crt_recombine.sv
// Garner recombination: m = mq + q*(((mp - mq) * qinv) mod p), bit-serial.
// Ports: clk, rst_n, start, p, q, mp, mq, qinv (W) -> m (2W), busy, done.
module crt_recombine
  import crt_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   p,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   mp,
  input  logic [W-1:0]   mq,
  input  logic [W-1:0]   qinv,
  output logic [2*W-1:0] m,
  output logic           busy,
  output logic           done
);

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]     r_p;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_mp;
  logic [W-1:0]     r_mq;
  logic [W-1:0]     r_qinv;
  logic [W-1:0]     r_mqr;
  logic [W-1:0]     r_d;
  logic [2*W-1:0]   r_prod;
  logic [2*W-1:0]   r_m;
  logic [CNT_W-1:0] r_cnt;

  logic [W-1:0]     w_mqr;
  logic [W-1:0]     w_d;
  logic [W-1:0]     w_h;
  logic [W-1:0]     w_hsh;
  logic [2*W-1:0]   w_prod_nxt;
  logic [2*W-1:0]   w_m_nxt;
  logic             w_last_q;
  logic             w_mm_start;
  logic             w_mm_done;

  // mq < q < 2p, so one conditional subtract reduces it mod p
  assign w_mqr = (r_mq >= r_p) ? r_mq - r_p : r_mq;

  // wrap-around in W bits yields mp - mqr + p exactly when mp < mqr
  assign w_d = (r_mp >= r_mqr) ? r_mp - r_mqr : r_mp - r_mqr + r_p;

  assign w_mm_start = (r_state == S_DIFF);

  modmul_serial #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_mm_start),
    .a     (r_d),
    .b     (r_qinv),
    .n     (r_p),
    .r     (w_h),
    .done  (w_mm_done)
  );

  // h stays stable in the multiplier while MUL_Q walks its bits
  assign w_hsh      = w_h << r_cnt;
  assign w_prod_nxt = {r_prod[2*W-2:0], 1'b0}
                    + (w_hsh[W-1] ? {{W{1'b0}}, r_q} : '0);
  assign w_m_nxt    = w_prod_nxt + {{W{1'b0}}, r_mq};
  assign w_last_q   = (r_cnt == CNT_W'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_REDUCE;
      S_REDUCE:  w_state_nxt = S_DIFF;
      S_DIFF:    w_state_nxt = S_MUL_MOD;
      S_MUL_MOD: if (w_mm_done) w_state_nxt = S_MUL_Q;
      S_MUL_Q:   if (w_last_q) w_state_nxt = S_FINISH;
      S_FINISH:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p    <= '0;
      r_q    <= '0;
      r_mp   <= '0;
      r_mq   <= '0;
      r_qinv <= '0;
      r_mqr  <= '0;
      r_d    <= '0;
      r_prod <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p    <= p;
            r_q    <= q;
            r_mp   <= mp;
            r_mq   <= mq;
            r_qinv <= qinv;
          end
        end
        S_REDUCE: r_mqr <= w_mqr;
        S_DIFF: begin
          r_d    <= w_d;
          r_cnt  <= '0;
          r_prod <= '0;
        end
        S_MUL_Q: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 1'b1;
          // result lands together with entry to FINISH
          if (w_last_q) r_m <= w_m_nxt;
        end
        default: ;
      endcase
    end
  end

  assign m    = r_m;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FINISH);

endmodule

// File: tb/tb_crt_recombine.sv
// Scoreboard bench for crt_recombine at W=8 (p=241, q=251, qinv=217).
// Driver queues expected m; monitor checks on every done pulse.
module tb_crt_recombine;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   p;
  logic [W-1:0]   q;
  logic [W-1:0]   mp;
  logic [W-1:0]   mq;
  logic [W-1:0]   qinv;
  logic [2*W-1:0] m;
  logic           busy;
  logic           done;

  int total;
  int bad;
  int exp_q[$];
  int last_m;

  crt_recombine #(
    .W     (W),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .q     (q),
    .mp    (mp),
    .mq    (mq),
    .qinv  (qinv),
    .m     (m),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=%0d required=none", 32'(m));
      end else begin
        chk("m_result", 32'(m), exp_q.pop_front());
      end
    end
  end

  task automatic run(input logic [W-1:0] a_mp, input logic [W-1:0] a_mq,
                     input int expv, input bit inj, input bit abort);
    int n;
    bit ok;
    bit seen;
    bit aborted;
    @(negedge clk);
    mp    = a_mp;
    mq    = a_mq;
    start = 1'b1;
    if (!abort) exp_q.push_back(expv);
    @(negedge clk);
    start   = 1'b0;
    n       = 1;
    ok      = 1'b1;
    seen    = 1'b0;
    aborted = 1'b0;
    while (n <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy || 32'(m) != last_m) ok = 1'b0;
      if (abort && n == 10) begin
        aborted = 1'b1;
        break;
      end
      if (inj) begin
        start = (n == 5);
        if (n == 5) begin
          mp = 8'd99;
          mq = 8'd7;
        end
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      chk("abort_m", 32'(m), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_hold", 32'(ok), 1);
      last_m = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      chk("latency", seen ? n : 0, 19);
      chk("busy_hold", 32'(ok), 1);
      if (seen) last_m = expv;
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    last_m = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    p      = 8'd241;
    q      = 8'd251;
    qinv   = 8'd217;
    mp     = '0;
    mq     = '0;
    repeat (2) @(negedge clk);
    chk("rst_m", 32'(m), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    run(8'd54,  8'd46,  12345, 1'b0, 1'b0);
    run(8'd8,   8'd239, 490,   1'b0, 1'b0);
    run(8'd9,   8'd250, 250,   1'b0, 1'b0);
    run(8'd0,   8'd0,   0,     1'b0, 1'b0);
    run(8'd240, 8'd250, 60490, 1'b0, 1'b0);
    run(8'd10,  8'd0,   251,   1'b0, 1'b0);
    run(8'd54,  8'd46,  12345, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    run(8'd8,   8'd239, 490,   1'b0, 1'b1);
    run(8'd240, 8'd250, 60490, 1'b0, 1'b0);
    run(8'd8,   8'd239, 490,   1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
